// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit-counter width; clamped so a degenerate WIDTH still yields a 1-bit counter.
  function automatic int cnt_width(input int width);
    int w;
    w = (width < MIN_WIDTH) ? MIN_WIDTH : width;
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational one-bit full adder; the only arithmetic cell of the serial adder.
module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | ((a_i ^ b_i) & cin_i);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell sequenced LSB first over WIDTH cycles.
// Optional subtract mode (sub_i port) is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic             busy_o
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             start_ready_q, done_valid_q, busy_q;

  logic [WIDTH-1:0] b_load_s;
  logic             cin_load_s;
  logic             fa_sum_s, fa_cout_s;

  // Subtraction is a + ~b + 1, so only the B image and initial carry change.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load_s   = sub_i ? ~b_i : b_i;
  assign cin_load_s = sub_i ? 1'b1 : cin_i;
`else
  assign b_load_s   = b_i;
  assign cin_load_s = cin_i;
`endif

  serial_fa_cell u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum_s),
    .cout_o (fa_cout_s)
  );

  // Next-state and datapath sequencing
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid_i && start_ready_q) begin
          a_d     = a_i;
          b_d     = b_load_s;
          carry_d = cin_load_s;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sum_d   = {fa_sum_s, sum_q[WIDTH-1:1]};
        carry_d = fa_cout_s;
        if (cnt_q == CNT_LAST) begin
          cout_d  = fa_cout_s;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (done_valid_q && done_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      sum_q         <= '0;
      cnt_q         <= '0;
      carry_q       <= 1'b0;
      cout_q        <= 1'b0;
      start_ready_q <= 1'b1;
      done_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      sum_q         <= sum_d;
      cnt_q         <= cnt_d;
      carry_q       <= carry_d;
      cout_q        <= cout_d;
      start_ready_q <= (state_d == ST_IDLE);
      done_valid_q  <= (state_d == ST_DONE);
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  assign start_ready_o = start_ready_q;
  assign done_valid_o  = done_valid_q;
  assign busy_o        = busy_q;
  assign sum_o         = sum_q;
  assign cout_o        = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): transaction model plus directed literals.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start_valid = 1'b0;
  logic         done_ready = 1'b0;
  logic [W-1:0] a_s = '0;
  logic [W-1:0] b_s = '0;
  logic         cin_s = 1'b0;
  logic         sub_s = 1'b0;
  logic         start_ready_o, cout_o, done_valid_o, busy_o;
  logic [W-1:0] sum_o;

  int n_chk = 0;
  int n_fail = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_valid_i (start_valid),
    .start_ready_o (start_ready_o),
    .a_i           (a_s),
    .b_i           (b_s),
    .cin_i         (cin_s),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i         (sub_s),
`endif
    .sum_o         (sum_o),
    .cout_o        (cout_o),
    .done_valid_o  (done_valid_o),
    .done_ready_i  (done_ready),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one op in flight, result due W edges after accept.
  bit         m_pending = 1'b0;
  int         m_cyc = 0;
  int         m_due = 0;
  logic [W:0] m_exp = '0;
  logic [W:0] m_held = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = 1'b0;
      m_held    = '0;
      m_cyc     = 0;
    end else begin
      if (m_pending) begin
        if (m_cyc >= m_due && done_ready) begin
          m_pending = 1'b0;
          m_held    = m_exp;
        end
      end else if (start_valid) begin
        m_pending = 1'b1;
        m_due     = m_cyc + 1 + W;
        if (sub_s)
          m_exp = {1'b0, a_s} + {1'b0, ~b_s} + (W+1)'(1);
        else
          m_exp = {1'b0, a_s} + {1'b0, b_s} + {{W{1'b0}}, cin_s};
      end
      m_cyc = m_cyc + 1;
    end
  end

  // Compare DUT outputs with the model on every falling edge
  always @(negedge clk) begin
    check("start_ready", start_ready_o, !m_pending);
    check("busy", busy_o, m_pending);
    check("done_valid", done_valid_o, m_pending && m_cyc >= m_due);
    if (m_pending && m_cyc >= m_due) begin
      check("sum", sum_o, m_exp[W-1:0]);
      check("cout", cout_o, m_exp[W]);
    end else if (!m_pending) begin
      check("sum_held", sum_o, m_held[W-1:0]);
      check("cout_held", cout_o, m_held[W]);
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic sb, input bit rnd_ready);
    int   n;
    logic acc;
    a_s = a; b_s = b; cin_s = c; sub_s = sb; start_valid = 1'b1;
    n = 0; acc = 1'b0;
    while (!acc && n < 200) begin
      if (rnd_ready) done_ready = ($urandom_range(0, 3) != 0);
      acc = start_ready_o;
      @(posedge clk); #2;
      n++;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    start_valid = 1'b0;
    a_s = W'($urandom); b_s = W'($urandom); cin_s = 1'($urandom); sub_s = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done_valid_o && lat < 100) begin
      @(posedge clk); #2;
      lat++;
    end
    if (!done_valid_o) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic handshake();
    done_ready = 1'b1;
    @(posedge clk); #2;
    done_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic sb, input logic [W-1:0] es, input logic ec);
    int lat;
    issue(a, b, c, sb, 1'b0);
    wait_done(lat);
    check("latency", lat, 8);
    check("lit_sum", sum_o, es);
    check("lit_cout", cout_o, ec);
  endtask

  initial begin
    int lat;
    int seen;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_start_ready", start_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done_valid", done_valid_o, 1'b0);
    check("rst_sum", sum_o, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #2;

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
    handshake();
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    handshake();
    run_op(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
    handshake();

    // done_ready high throughout RUN must not end the operation early
    done_ready = 1'b1;
    run_op(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1);
    @(posedge clk); #2;
    done_ready = 1'b0;
    check("early_ready_idle", start_ready_o, 1'b1);

    // Backpressure: stall in DONE while pulsing start_valid
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);
    a_s = 8'h01; b_s = 8'h02; cin_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start_valid = (i % 2 == 0);
      @(posedge clk); #2;
      check("bp_start_ready", start_ready_o, 1'b0);
      check("bp_sum", sum_o, 8'h46);
      check("bp_done_valid", done_valid_o, 1'b1);
    end
    start_valid = 1'b1;
    handshake();
    check("bp_idle_ready", start_ready_o, 1'b1);
    check("bp_idle_busy", busy_o, 1'b0);
    @(posedge clk); #2;
    start_valid = 1'b0;
    check("bp_accept_busy", busy_o, 1'b1);
    wait_done(lat);
    check("bp_second_sum", sum_o, 8'h03);
    handshake();

    // Reset in the middle of RUN
    issue(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("mid_busy_pre", busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", sum_o, 8'h00);
    check("mid_rst_cout", cout_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_ready", start_ready_o, 1'b1);
    check("mid_rst_dv", done_valid_o, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #2;
      if (done_valid_o) seen++;
    end
    check("mid_rst_no_done", seen, 0);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);
    handshake();

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    handshake();
    run_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
    handshake();
`endif

    // Back-to-back random sweep with random consumer stalls
    for (int i = 0; i < 1000; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1);
    end
    done_ready = 1'b1;
    lat = 0;
    while (busy_o && lat < 100) begin
      @(posedge clk); #2;
      lat++;
    end
    check("drain_idle", busy_o, 1'b0);
    done_ready = 1'b0;
    @(posedge clk); #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
